// File: rtl/apb_ctrl_pkg.sv
// Shared types, default widths and width helper for the APB master arbiter.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_ctrl_state_t;

  localparam int unsigned APB_ADDR_W = 16;
  localparam int unsigned APB_DATA_W = 32;

  // Index width for n items, never less than 1 bit.
  function automatic int unsigned clog2(input int unsigned n);
    clog2 = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) clog2 = i + 1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above i_ptr, wrapping modulo N.
module rr_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic          w_found;
  logic [IW-1:0] w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = IW'((32'(i_ptr) + k) % N);
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NREQ requesters.
// Optional ACCESS-phase abort counter enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ-1:0]          i_req_write,
  input  logic [NREQ*ADDR_W-1:0]   i_req_addr,
  input  logic [NREQ*DATA_W-1:0]   i_req_wdata,
  output logic [NREQ-1:0]          o_req_ready,
  output logic [NREQ-1:0]          o_rsp_valid,
  output logic [DATA_W-1:0]        o_rsp_rdata,
  output logic                     o_rsp_err,
  output logic                     o_psel,
  output logic                     o_penable,
  output logic                     o_pwrite,
  output logic [ADDR_W-1:0]        o_paddr,
  output logic [DATA_W-1:0]        o_pwdata,
  input  logic [DATA_W-1:0]        i_prdata,
  input  logic                     i_pready
);

  localparam int unsigned IW = clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("apb_master_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES at least 2");
  end

  apb_ctrl_state_t   r_state;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_grant;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_psel;
  logic              r_penable;

  logic [NREQ-1:0]   w_gnt;
  logic [IW-1:0]     w_idx;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_arbiter (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  // Constant-index mux keeps the flattened request fields free of variable slicing.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_idx == IW'(i)) begin
        w_sel_write = i_req_write[i];
        w_sel_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = i_req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign o_req_ready = (r_state == IDLE) ? (w_gnt & i_req_valid) : '0;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_psel      = r_psel;
  assign o_penable   = r_penable;
  assign o_pwrite    = r_write;
  assign o_paddr     = r_addr;
  assign o_pwdata    = r_wdata;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TW = clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] r_tcnt;
  logic          r_rsp_err;
  assign o_rsp_err = r_rsp_err;
`else
  assign o_rsp_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_tcnt      <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= '0;
      unique case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_write <= w_sel_write;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_grant <= w_idx;
            r_ptr   <= (32'(w_idx) == NREQ - 1) ? '0 : w_idx + IW'(1);
            r_psel  <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          r_tcnt    <= '0;
`endif
        end
        ACCESS: begin
          if (i_pready) begin
            r_rsp_rdata          <= r_write ? '0 : i_prdata;
            r_rsp_valid[r_grant] <= 1'b1;
            r_psel               <= 1'b0;
            r_penable            <= 1'b0;
            r_state              <= IDLE;
`ifdef APB_TIMEOUT_EN
            r_rsp_err            <= 1'b0;
          end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_rdata          <= '0;
            r_rsp_err            <= 1'b1;
            r_rsp_valid[r_grant] <= 1'b1;
            r_psel               <= 1'b0;
            r_penable            <= 1'b0;
            r_state              <= IDLE;
          end else begin
            r_tcnt               <= r_tcnt + TW'(1);
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter (NREQ=4, 16-bit addr, 32-bit data).
module tb_apb_master_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 32;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [AW-1:0]        paddr;
  logic [DW-1:0]        pwdata;
  logic [DW-1:0]        prdata;
  logic                 pready;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master_arbiter #(
    .NREQ           (NREQ),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req_valid (req_valid),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_psel      (psel),
    .o_penable   (penable),
    .o_pwrite    (pwrite),
    .o_paddr     (paddr),
    .o_pwdata    (pwdata),
    .i_prdata    (prdata),
    .i_pready    (pready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 2ns after the next rising edge; inputs are driven there and
  // outputs checked 1ns later.
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    pready    = 1'b1;
    next();
    next();
    #1;
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    reset = 1'b0;

    // Single write from requester 0, zero wait states.
    next();
    req_valid = 4'b0001;
    req_write = 4'b0001;
    req_addr[0*AW +: AW]  = 16'h0010;
    req_wdata[0*DW +: DW] = 32'hDEADBEEF;
    #1;
    chk("wr_ready_c0", 64'(req_ready), 64'b0001);
    chk("wr_psel_c0", 64'(psel), 64'd0);
    next();
    req_valid = '0;
    #1;
    chk("wr_psel_c1", 64'(psel), 64'd1);
    chk("wr_penable_c1", 64'(penable), 64'd0);
    chk("wr_paddr_c1", 64'(paddr), 64'h0010);
    chk("wr_pwrite_c1", 64'(pwrite), 64'd1);
    chk("wr_pwdata_c1", 64'(pwdata), 64'hDEADBEEF);
    next();
    #1;
    chk("wr_psel_c2", 64'(psel), 64'd1);
    chk("wr_penable_c2", 64'(penable), 64'd1);
    chk("wr_rsp_c2", 64'(rsp_valid), 64'd0);
    next();
    #1;
    chk("wr_rsp_c3", 64'(rsp_valid), 64'b0001);
    chk("wr_err_c3", 64'(rsp_err), 64'd0);
    chk("wr_psel_c3", 64'(psel), 64'd0);
    chk("wr_penable_c3", 64'(penable), 64'd0);
    next();
    #1;
    chk("wr_rsp_c4", 64'(rsp_valid), 64'd0);
    chk("wr_paddr_hold", 64'(paddr), 64'h0010);

    // Read from requester 2 with three wait states.
    pready = 1'b0;
    req_valid = 4'b0100;
    req_write = 4'b0000;
    req_addr[2*AW +: AW] = 16'h0040;
    #1;
    chk("rd_ready_c0", 64'(req_ready), 64'b0100);
    next();
    req_valid = '0;
    #1;
    chk("rd_psel_c1", 64'(psel), 64'd1);
    chk("rd_paddr_c1", 64'(paddr), 64'h0040);
    chk("rd_pwrite_c1", 64'(pwrite), 64'd0);
    for (int c = 2; c <= 5; c++) begin
      next();
      if (c == 5) begin
        pready = 1'b1;
        prdata = 32'h12345678;
      end
      #1;
      chk("rd_penable_wait", 64'(penable), 64'd1);
      chk("rd_rsp_wait", 64'(rsp_valid), 64'd0);
    end
    next();
    pready = 1'b0;
    prdata = '0;
    #1;
    chk("rd_rsp_c6", 64'(rsp_valid), 64'b0100);
    chk("rd_rdata_c6", 64'(rsp_rdata), 64'h12345678);
    chk("rd_psel_c6", 64'(psel), 64'd0);

    // Asynchronous reset while requester 1 is in ACCESS.
    next();
    req_valid = 4'b0010;
    req_addr[1*AW +: AW] = 16'h0123;
    #1;
    chk("ar_ready_c0", 64'(req_ready), 64'b0010);
    next();
    req_valid = '0;
    next();
    #1;
    chk("ar_penable_c2", 64'(penable), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_psel_async", 64'(psel), 64'd0);
    chk("ar_penable_async", 64'(penable), 64'd0);
    next();
    reset = 1'b0;
    pready = 1'b1;
    #1;
    chk("ar_rsp_after", 64'(rsp_valid), 64'd0);
    next();
    #1;
    chk("ar_rsp_after2", 64'(rsp_valid), 64'd0);

    // All four requesting writes continuously: grants 0,1,2,3,0.
    req_valid = 4'b1111;
    req_write = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      chk("rr_rsp", 64'(rsp_valid), (k == 0) ? 64'd0 : 64'(4'b0001 << ((k - 1) % 4)));
      next();
      if (k == 4) req_valid = '0;
      #1;
      chk("rr_ready_setup", 64'(req_ready), 64'd0);
      next();
      #1;
      chk("rr_ready_access", 64'(req_ready), 64'd0);
      next();
    end
    #1;
    chk("rr_rsp_last", 64'(rsp_valid), 64'b0001);

    // Requester 1 withdraws a request while requester 3 owns the bus.
    pready = 1'b0;
    req_valid = 4'b1000;
    req_write = 4'b0000;
    #1;
    chk("wd_ready_c0", 64'(req_ready), 64'b1000);
    next();
    req_valid = 4'b0010;
    #1;
    chk("wd_ready_busy", 64'(req_ready), 64'd0);
    next();
    req_valid = '0;
    next();
    pready = 1'b1;
    prdata = 32'h0000A5A5;
    next();
    pready = 1'b0;
    prdata = '0;
    #1;
    chk("wd_rsp", 64'(rsp_valid), 64'b1000);
    chk("wd_rdata", 64'(rsp_rdata), 64'hA5A5);
    chk("wd_ready_idle", 64'(req_ready), 64'd0);
    next();
    #1;
    chk("wd_rsp_after", 64'(rsp_valid), 64'd0);
    chk("wd_psel_idle", 64'(psel), 64'd0);

`ifdef APB_TIMEOUT_EN
    // Timeout abort: pready never rises.
    req_valid = 4'b0001;
    #1;
    chk("to_ready", 64'(req_ready), 64'b0001);
    next();
    req_valid = '0;
    for (int a = 0; a < 16; a++) begin
      next();
      #1;
      chk("to_penable", 64'(penable), 64'd1);
    end
    next();
    #1;
    chk("to_rsp", 64'(rsp_valid), 64'b0001);
    chk("to_err", 64'(rsp_err), 64'd1);
    chk("to_rdata", 64'(rsp_rdata), 64'd0);
    chk("to_psel", 64'(psel), 64'd0);

    // pready on the final allowed cycle completes normally.
    next();
    req_valid = 4'b0010;
    #1;
    chk("to2_ready", 64'(req_ready), 64'b0010);
    next();
    req_valid = '0;
    for (int a = 0; a < 16; a++) begin
      next();
      if (a == 15) begin
        pready = 1'b1;
        prdata = 32'h00000055;
      end
      #1;
      chk("to2_penable", 64'(penable), 64'd1);
    end
    next();
    pready = 1'b0;
    #1;
    chk("to2_rsp", 64'(rsp_valid), 64'b0010);
    chk("to2_err", 64'(rsp_err), 64'd0);
    chk("to2_rdata", 64'(rsp_rdata), 64'h55);
`else
    chk("err_tied", 64'(rsp_err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
